ped_request_unit: RTL and testbench



---
 rtl/ped_request_unit_pkg.sv | 23 ++
 rtl/ped_request_unit_if.sv | 26 ++
 rtl/ped_request_unit_btn_debounce.sv | 62 ++++++
 rtl/ped_request_unit.sv | 94 +++++++++
 tb/tb_ped_request_unit.sv | 163 ++++++++++++++++
 5 files changed

// File: rtl/ped_request_unit_pkg.sv
// rtl/ped_request_unit_pkg.sv - shared phase codes, lamp codes and helpers for the pedestrian request unit
package ped_pkg;

    localparam int PHASE_W = 3;

    // Controller phase codes; 6 and 7 are never legitimately produced
    localparam logic [PHASE_W-1:0] PH_F1_GO    = 3'd0;
    localparam logic [PHASE_W-1:0] PH_F1_AMB   = 3'd1;
    localparam logic [PHASE_W-1:0] PH_F2_GO    = 3'd2;
    localparam logic [PHASE_W-1:0] PH_F2_AMB   = 3'd3;
    localparam logic [PHASE_W-1:0] PH_WALK     = 3'd4;
    localparam logic [PHASE_W-1:0] PH_WALK_CLR = 3'd5;

    // One-hot lamp codes shared with the controller
    localparam logic [2:0] RED   = 3'b100;
    localparam logic [2:0] AMBER = 3'b010;
    localparam logic [2:0] GREEN = 3'b001;

    function automatic logic phase_invalid(input logic [PHASE_W-1:0] p);
        return p > PH_WALK_CLR;
    endfunction

endpackage

// File: rtl/ped_request_unit_if.sv
// rtl/ped_request_unit_if.sv - button/phase inputs and request outputs between the unit and the controller
interface ped_request_unit_if #(
    parameter int N_BTN = 10
) ();
    import ped_pkg::*;

    logic [N_BTN-1:0]   btn;
    logic [PHASE_W-1:0] phase;
    logic               ped_call;
    logic               ped_urgent;
    logic [N_BTN-1:0]   req_pending;
    logic [N_BTN-1:0]   wait_lamp;
    logic               served;
    logic               phase_err;

    modport slave (
        input  btn, phase,
        output ped_call, ped_urgent, req_pending, wait_lamp, served, phase_err
    );

    modport master (
        output btn, phase,
        input  ped_call, ped_urgent, req_pending, wait_lamp, served, phase_err
    );

endinterface

// File: rtl/ped_request_unit_btn_debounce.sv
// rtl/ped_request_unit_btn_debounce.sv - two-flop synchroniser and counter debouncer for one push button
module btn_debounce #(
    parameter int DEB_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_i,
    output logic stable_o,
    output logic press_o
);
    localparam int CNT_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;

    logic             sync1_q;
    logic             sync2_q;
    logic             stable_q;
    logic             stable_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             b_s;

    assign b_s = sync2_q;

    // Bring the asynchronous button into the clock domain
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= btn_i;
            sync2_q <= sync1_q;
        end
    end

    // Accept a new level only after it has differed for DEB_CYCLES consecutive edges
    always_comb begin
        stable_d = stable_q;
        cnt_d    = '0;
        if (b_s != stable_q) begin
            if (cnt_q == CNT_W'(DEB_CYCLES - 1)) begin
                stable_d = b_s;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // Debounced level and its qualification counter
    always_ff @(posedge clk) begin
        if (rst) begin
            stable_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
        end
    end

    // Strobe is valid in the cycle before the edge on which stable rises
    assign press_o  = stable_d & ~stable_q;
    assign stable_o = stable_q;

endmodule

// File: rtl/ped_request_unit.sv
// rtl/ped_request_unit.sv - latches debounced pedestrian requests and raises call/urgent to the controller
module ped_request_unit
    import ped_pkg::*;
#(
    parameter int N_BTN      = 10,
    parameter int DEB_CYCLES = 4,
    parameter int MAX_WAIT   = 200,
    parameter int WAIT_W     = 8
) (
    input logic               clk,
    input logic               rst,
    ped_request_unit_if.slave bus
);
    logic [N_BTN-1:0]   press;
    logic [N_BTN-1:0]   btn_stable;
    logic [N_BTN-1:0]   pending_q;
    logic [N_BTN-1:0]   pending_d;
    logic [PHASE_W-1:0] phase_q;
    logic               phase_err_q;
    logic               served_q;
    logic               served_d;
    logic [WAIT_W-1:0]  wait_q;
    logic [WAIT_W-1:0]  wait_d;
    logic               in_walk;
    logic               walk_entry;
    logic               ped_call;
    logic               unused_stable;

    for (genvar gi = 0; gi < N_BTN; gi++) begin : g_deb
        btn_debounce #(
            .DEB_CYCLES(DEB_CYCLES)
        ) u_deb (
            .clk     (clk),
            .rst     (rst),
            .btn_i   (bus.btn[gi]),
            .stable_o(btn_stable[gi]),
            .press_o (press[gi])
        );
    end

    // Debounced levels are not needed here; only press strobes matter
    assign unused_stable = ^btn_stable;

    assign in_walk    = (bus.phase == PH_WALK);
    assign walk_entry = in_walk && (phase_q != PH_WALK);
    assign ped_call   = |pending_q;

    // Walk entry serves everything; presses during the walk itself are already granted
    always_comb begin
        pending_d = pending_q;
        served_d  = 1'b0;
        if (walk_entry) begin
            pending_d = '0;
            served_d  = |pending_q;
        end else if (!in_walk) begin
            pending_d = pending_q | press;
        end
    end

    // Wait counter runs only while a call is outstanding and saturates at MAX_WAIT
    always_comb begin
        wait_d = wait_q;
        if (!ped_call || walk_entry) begin
            wait_d = '0;
        end else if (wait_q != WAIT_W'(MAX_WAIT)) begin
            wait_d = wait_q + 1'b1;
        end
    end

    // Request, phase-tracking and wait-counter state
    always_ff @(posedge clk) begin
        if (rst) begin
            pending_q   <= '0;
            phase_q     <= PH_F1_GO;
            phase_err_q <= 1'b0;
            served_q    <= 1'b0;
            wait_q      <= '0;
        end else begin
            pending_q   <= pending_d;
            phase_q     <= bus.phase;
            phase_err_q <= phase_invalid(bus.phase);
            served_q    <= served_d;
            wait_q      <= wait_d;
        end
    end

    assign bus.ped_call    = ped_call;
    assign bus.ped_urgent  = ped_call && (wait_q == WAIT_W'(MAX_WAIT));
    assign bus.req_pending = pending_q;
    assign bus.wait_lamp   = pending_q;
    assign bus.served      = served_q;
    assign bus.phase_err   = phase_err_q;

endmodule

// File: tb/tb_ped_request_unit.sv
// tb/tb_ped_request_unit.sv - directed table-driven bench for the pedestrian request unit
module tb_ped_request_unit;

    localparam int N = 10;

    typedef struct {
        logic [N-1:0] btn;
        logic [2:0]   phase;
        int           cycles;
        logic [N-1:0] exp_pending;
        logic         exp_urgent;
        int           exp_served_cnt;
        int           exp_err_cnt;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    int   n_tests = 0;
    int   n_fail  = 0;

    ped_request_unit_if #(.N_BTN(N)) bus ();

    ped_request_unit #(
        .N_BTN     (N),
        .DEB_CYCLES(4),
        .MAX_WAIT  (200),
        .WAIT_W    (8)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_outputs(input string tag, input logic [N-1:0] pend, input logic urg);
        chk({tag, " req_pending"}, 32'(bus.req_pending), 32'(pend));
        chk({tag, " wait_lamp"},   32'(bus.wait_lamp),   32'(pend));
        chk({tag, " ped_call"},    32'(bus.ped_call),    32'(pend != '0));
        chk({tag, " ped_urgent"},  32'(bus.ped_urgent),  32'(urg));
    endtask

    vec_t vecs[19];

    initial begin
        int served_cnt;
        int err_cnt;
        int urg_low;

        vecs[0]  = '{10'h008, 3'd0, 3,  10'h000, 1'b0, 0, 0};
        vecs[1]  = '{10'h000, 3'd0, 8,  10'h000, 1'b0, 0, 0};
        vecs[2]  = '{10'h008, 3'd0, 5,  10'h000, 1'b0, 0, 0};
        vecs[3]  = '{10'h008, 3'd0, 1,  10'h008, 1'b0, 0, 0};
        vecs[4]  = '{10'h000, 3'd0, 10, 10'h008, 1'b0, 0, 0};
        vecs[5]  = '{10'h201, 3'd3, 6,  10'h209, 1'b0, 0, 0};
        vecs[6]  = '{10'h000, 3'd3, 1,  10'h209, 1'b0, 0, 0};
        vecs[7]  = '{10'h000, 3'd4, 1,  10'h000, 1'b0, 1, 0};
        vecs[8]  = '{10'h000, 3'd4, 10, 10'h000, 1'b0, 0, 0};
        vecs[9]  = '{10'h004, 3'd4, 6,  10'h000, 1'b0, 0, 0};
        vecs[10] = '{10'h004, 3'd4, 4,  10'h000, 1'b0, 0, 0};
        vecs[11] = '{10'h000, 3'd5, 8,  10'h000, 1'b0, 0, 0};
        vecs[12] = '{10'h004, 3'd5, 6,  10'h004, 1'b0, 0, 0};
        vecs[13] = '{10'h000, 3'd7, 1,  10'h004, 1'b0, 0, 1};
        vecs[14] = '{10'h000, 3'd5, 3,  10'h004, 1'b0, 0, 0};
        vecs[15] = '{10'h000, 3'd6, 1,  10'h004, 1'b0, 0, 1};
        vecs[16] = '{10'h000, 3'd0, 1,  10'h004, 1'b0, 0, 0};
        vecs[17] = '{10'h000, 3'd4, 1,  10'h000, 1'b0, 1, 0};
        vecs[18] = '{10'h000, 3'd2, 2,  10'h000, 1'b0, 0, 0};

        rst       = 1'b1;
        bus.btn   = '0;
        bus.phase = 3'd0;
        repeat (3) step();
        chk_outputs("reset", '0, 1'b0);
        chk("reset served",    32'(bus.served),    32'd0);
        chk("reset phase_err", 32'(bus.phase_err), 32'd0);

        rst = 1'b0;
        served_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (bus.served || bus.ped_call || bus.ped_urgent || bus.phase_err || (bus.req_pending != '0))
                served_cnt++;
        end
        chk("idle 20 cycles active outputs", 32'(served_cnt), 32'd0);

        for (int v = 0; v < 19; v++) begin
            bus.btn    = vecs[v].btn;
            bus.phase  = vecs[v].phase;
            served_cnt = 0;
            err_cnt    = 0;
            for (int c = 0; c < vecs[v].cycles; c++) begin
                step();
                served_cnt += int'(bus.served);
                err_cnt    += int'(bus.phase_err);
            end
            chk_outputs($sformatf("vec%0d", v), vecs[v].exp_pending, vecs[v].exp_urgent);
            chk($sformatf("vec%0d served cycles", v), 32'(served_cnt), 32'(vecs[v].exp_served_cnt));
            chk($sformatf("vec%0d phase_err cycles", v), 32'(err_cnt), 32'(vecs[v].exp_err_cnt));
        end

        // Urgent: request latched with phase stuck at PH_F2_GO
        bus.btn   = 10'h020;
        bus.phase = 3'd2;
        repeat (6) step();
        chk_outputs("urgent latch", 10'h020, 1'b0);
        bus.btn = '0;
        repeat (199) step();
        chk_outputs("urgent after 199", 10'h020, 1'b0);
        step();
        chk_outputs("urgent after 200", 10'h020, 1'b1);
        urg_low = 0;
        for (int i = 0; i < 50; i++) begin
            step();
            if (!bus.ped_urgent) urg_low++;
        end
        chk("urgent held low cycles", 32'(urg_low), 32'd0);
        bus.phase = 3'd4;
        step();
        chk_outputs("urgent walk entry", '0, 1'b0);
        chk("urgent walk served", 32'(bus.served), 32'd1);
        step();
        chk("urgent walk served next", 32'(bus.served), 32'd0);

        // Reset mid-operation with five requests pending
        bus.phase = 3'd0;
        repeat (2) step();
        bus.btn = 10'h1D2;
        repeat (6) step();
        chk_outputs("pre-reset", 10'h1D2, 1'b0);
        bus.btn = '0;
        rst     = 1'b1;
        step();
        chk_outputs("mid reset", '0, 1'b0);
        chk("mid reset served", 32'(bus.served), 32'd0);
        repeat (2) step();
        rst = 1'b0;
        served_cnt = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            served_cnt += int'(bus.served);
        end
        chk_outputs("post reset", '0, 1'b0);
        chk("post reset served cycles", 32'(served_cnt), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
